// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = minuend - subtrahend - borrow_in.
module full_subtractor (
  input  logic minuend,
  input  logic subtrahend,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = minuend ^ subtrahend ^ borrow_in;
  assign borrow_out = (~minuend & subtrahend) | (~(minuend ^ subtrahend) & borrow_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A-B (LSB first) around a single full_subtractor with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_sr_reg, b_sr_reg;
  logic [WIDTH-2:0]  res_sr_reg;
  logic [WIDTH-1:0]  res_next;
  logic              borrow_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  diff_reg;
  logic              borrow_out_reg;
  logic              diff_bit, borrow_out;
  logic              last_bit;

  full_subtractor u_fs (
    .minuend    (a_sr_reg[0]),
    .subtrahend (b_sr_reg[0]),
    .borrow_in  (borrow_reg),
    .diff       (diff_bit),
    .borrow_out (borrow_out)
  );

  // The final diff bit is folded in directly so the result is ready on entry to DONE.
  assign res_next = {diff_bit, res_sr_reg};
  assign last_bit = (cnt_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_bit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      res_sr_reg     <= '0;
      borrow_reg     <= 1'b0;
      cnt_reg        <= '0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_sr_reg   <= a;
            b_sr_reg   <= b;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
          end
        end
        S_RUN: begin
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          res_sr_reg <= res_next[WIDTH-1:1];
          borrow_reg <= borrow_out;
          if (last_bit) begin
            diff_reg       <= res_next;
            borrow_out_reg <= borrow_out;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_reg;

  // On the last RUN cycle the operand LSBs hold the original sign bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == S_RUN && last_bit) begin
      ovf_reg <= (a_sr_reg[0] ^ b_sr_reg[0]) & (diff_bit ^ a_sr_reg[0]);
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy   = (state_reg != S_IDLE);
  assign done   = (state_reg == S_DONE);
  assign diff   = diff_reg;
  assign borrow = borrow_out_reg;

endmodule
